// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus the pmem scheduler state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_block;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } lc3b_pmem_sched_state;

endpackage

// File: rtl/pmem_sched_if.sv
// Cache-side and memory-side pmem signals seen by the scheduler.
interface pmem_sched_if;
  import lc3b_types::*;

  logic        icache_pmem_read;
  lc3b_word    icache_pmem_address;
  logic        icache_pmem_resp;
  logic        dcache_pmem_read;
  logic        dcache_pmem_write;
  lc3b_word    dcache_pmem_address;
  lc3b_c_block dcache_pmem_wdata;
  logic        dcache_pmem_resp;
  logic        pmem_resp;
  logic        pmem_read;
  logic        pmem_write;
  lc3b_word    pmem_address;
  lc3b_c_block pmem_wdata;
  logic        ld_regs;

  // Scheduler side.
  modport master (
    input  icache_pmem_read, icache_pmem_address,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    input  pmem_resp,
    output icache_pmem_resp, dcache_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    output ld_regs
  );

  // Caches and memory side.
  modport slave (
    output icache_pmem_read, icache_pmem_address,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
    output pmem_resp,
    input  icache_pmem_resp, dcache_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  ld_regs
  );

endinterface

// File: rtl/pmem_sched_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != WIDTH'(LIMIT)))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pmem_sched.sv
// Shares the pmem port between icache and dcache: dcache-first arbitration
// with bounded icache starvation; ld_regs freezes the pipeline meanwhile.
module pmem_sched
  import lc3b_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst_n,
  pmem_sched_if.master bus
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  lc3b_pmem_sched_state state_q, state_d;
  logic [CW-1:0]        starve_cnt;
  logic                 i_req, d_req;
  logic                 starve_inc, starve_clr;

  assign i_req = bus.icache_pmem_read;
  assign d_req = bus.dcache_pmem_read | bus.dcache_pmem_write;

  always_comb begin
    state_d    = state_q;
    starve_inc = 1'b0;
    starve_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req && i_req) begin
          if (starve_cnt == CW'(STARVE_LIMIT)) begin
            state_d    = GNT_I;
            starve_clr = 1'b1;
          end else begin
            state_d    = GNT_D;
            starve_inc = 1'b1;
          end
        end else if (d_req) begin
          state_d = GNT_D;
        end else if (i_req) begin
          state_d    = GNT_I;
          starve_clr = 1'b1;
        end
      end
      GNT_I:   if (bus.pmem_resp) state_d = IDLE;
      GNT_D:   if (bus.pmem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  sat_counter #(
    .WIDTH (CW),
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (starve_inc),
    .clr_i (starve_clr),
    .cnt_o (starve_cnt)
  );

  // Outputs decode from the registered state only, so reset clears them at once.
  always_comb begin
    bus.pmem_read        = 1'b0;
    bus.pmem_write       = 1'b0;
    bus.pmem_address     = '0;
    bus.pmem_wdata       = '0;
    bus.icache_pmem_resp = 1'b0;
    bus.dcache_pmem_resp = 1'b0;
    unique case (state_q)
      GNT_I: begin
        bus.pmem_read        = bus.icache_pmem_read;
        bus.pmem_address     = bus.icache_pmem_address;
        bus.icache_pmem_resp = bus.pmem_resp;
      end
      GNT_D: begin
        bus.pmem_write       = bus.dcache_pmem_write;
        bus.pmem_read        = bus.dcache_pmem_read & ~bus.dcache_pmem_write;
        bus.pmem_address     = bus.dcache_pmem_address;
        bus.pmem_wdata       = bus.dcache_pmem_wdata;
        bus.dcache_pmem_resp = bus.pmem_resp;
      end
      default: ;
    endcase
  end

  assign bus.ld_regs = (state_q == IDLE) && !(i_req || d_req);

  a_dcache_rw_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !((state_q == GNT_D) && bus.dcache_pmem_read && bus.dcache_pmem_write));

endmodule

// File: tb/tb_pmem_sched.sv
// Directed bench for pmem_sched: cycle vector table plus starvation and reset sequences.
module tb_pmem_sched;
  import lc3b_types::*;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  pmem_sched_if bus();

  pmem_sched #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] WB = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

  typedef struct {
    logic         i_rd;
    logic [15:0]  i_addr;
    logic         d_rd;
    logic         d_wr;
    logic [15:0]  d_addr;
    logic [127:0] d_wdata;
    logic         resp;
    logic         e_rd;
    logic         e_wr;
    logic [15:0]  e_addr;
    logic [127:0] e_wdata;
    logic         e_iresp;
    logic         e_dresp;
    logic         e_ld;
    logic [1:0]   e_state;
    int           e_starve;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic i_rd, input logic [15:0] i_addr, input logic d_rd,
                     input logic d_wr, input logic [15:0] d_addr, input logic [127:0] d_wdata,
                     input logic resp, input logic e_rd, input logic e_wr,
                     input logic [15:0] e_addr, input logic [127:0] e_wdata, input logic e_iresp,
                     input logic e_dresp, input logic e_ld, input logic [1:0] e_state,
                     input int e_starve);
    vec_t v;
    v.i_rd = i_rd; v.i_addr = i_addr; v.d_rd = d_rd; v.d_wr = d_wr;
    v.d_addr = d_addr; v.d_wdata = d_wdata; v.resp = resp;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_iresp = e_iresp; v.e_dresp = e_dresp; v.e_ld = e_ld;
    v.e_state = e_state; v.e_starve = e_starve;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic i_rd, input logic [15:0] i_addr, input logic d_rd,
                       input logic d_wr, input logic [15:0] d_addr,
                       input logic [127:0] d_wdata, input logic resp);
    bus.icache_pmem_read    = i_rd;
    bus.icache_pmem_address = i_addr;
    bus.dcache_pmem_read    = d_rd;
    bus.dcache_pmem_write   = d_wr;
    bus.dcache_pmem_address = d_addr;
    bus.dcache_pmem_wdata   = d_wdata;
    bus.pmem_resp           = resp;
  endtask

  task automatic chk_outputs(input string tag, input int idx, input logic rd, input logic wr,
                             input logic [15:0] addr, input logic [127:0] wd,
                             input logic ir, input logic dr, input logic ld);
    chk({tag, ".pmem_read"},  idx, 128'(bus.pmem_read),        128'(rd));
    chk({tag, ".pmem_write"}, idx, 128'(bus.pmem_write),       128'(wr));
    chk({tag, ".pmem_addr"},  idx, 128'(bus.pmem_address),     128'(addr));
    chk({tag, ".pmem_wdata"}, idx, bus.pmem_wdata,             wd);
    chk({tag, ".icache_resp"},idx, 128'(bus.icache_pmem_resp), 128'(ir));
    chk({tag, ".dcache_resp"},idx, 128'(bus.dcache_pmem_resp), 128'(dr));
    chk({tag, ".ld_regs"},    idx, 128'(bus.ld_regs),          128'(ld));
  endtask

  int d_grants;
  bit got_i;

  initial begin
    // i_rd i_addr d_rd d_wr d_addr wdata resp | rd wr addr wdata iresp dresp ld state starve
    // icache-only fill, memory answers on the 4th cycle of the grant request
    add(1, 16'h1230, 0, 0, 16'h0000, '0, 0,  0, 0, 16'h0000, '0, 0, 0, 0, 2'd0, 0);
    add(1, 16'h1230, 0, 0, 16'h0000, '0, 0,  1, 0, 16'h1230, '0, 0, 0, 0, 2'd1, 0);
    add(1, 16'h1230, 0, 0, 16'h0000, '0, 0,  1, 0, 16'h1230, '0, 0, 0, 0, 2'd1, 0);
    add(1, 16'h1230, 0, 0, 16'h0000, '0, 1,  1, 0, 16'h1230, '0, 1, 0, 0, 2'd1, 0);
    add(0, 16'h0000, 0, 0, 16'h0000, '0, 0,  0, 0, 16'h0000, '0, 0, 0, 1, 2'd0, 0);
    // stray response in IDLE
    add(0, 16'h0000, 0, 0, 16'h0000, '0, 1,  0, 0, 16'h0000, '0, 0, 0, 1, 2'd0, 0);
    add(0, 16'h0000, 0, 0, 16'h0000, '0, 0,  0, 0, 16'h0000, '0, 0, 0, 1, 2'd0, 0);
    // write-back
    add(0, 16'h0000, 0, 1, 16'hA000, WB, 0,  0, 0, 16'h0000, '0, 0, 0, 0, 2'd0, 0);
    add(0, 16'h0000, 0, 1, 16'hA000, WB, 0,  0, 1, 16'hA000, WB, 0, 0, 0, 2'd2, 0);
    add(0, 16'h0000, 0, 1, 16'hA000, WB, 1,  0, 1, 16'hA000, WB, 0, 1, 0, 2'd2, 0);
    add(0, 16'h0000, 0, 0, 16'h0000, '0, 0,  0, 0, 16'h0000, '0, 0, 0, 1, 2'd0, 0);
    // simultaneous requests: dcache first, one IDLE cycle, then icache
    add(1, 16'h0040, 1, 0, 16'h8000, '0, 0,  0, 0, 16'h0000, '0, 0, 0, 0, 2'd0, 0);
    add(1, 16'h0040, 1, 0, 16'h8000, '0, 0,  1, 0, 16'h8000, '0, 0, 0, 0, 2'd2, 1);
    add(1, 16'h0040, 1, 0, 16'h8000, '0, 1,  1, 0, 16'h8000, '0, 0, 1, 0, 2'd2, 1);
    add(1, 16'h0040, 0, 0, 16'h0000, '0, 0,  0, 0, 16'h0000, '0, 0, 0, 0, 2'd0, 1);
    add(1, 16'h0040, 0, 0, 16'h0000, '0, 0,  1, 0, 16'h0040, '0, 0, 0, 0, 2'd1, 0);
    add(1, 16'h0040, 0, 0, 16'h0000, '0, 1,  1, 0, 16'h0040, '0, 1, 0, 0, 2'd1, 0);
    add(0, 16'h0000, 0, 0, 16'h0000, '0, 0,  0, 0, 16'h0000, '0, 0, 0, 1, 2'd0, 0);

    // Reset state
    rst_n = 1'b0;
    drive(0, '0, 0, 0, '0, '0, 0);
    #12;
    chk_outputs("reset", 0, 0, 0, 16'h0000, '0, 0, 0, 1);
    chk("reset.state",  0, 128'(dut.state_q),    128'(IDLE));
    chk("reset.starve", 0, 128'(dut.starve_cnt), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: inputs applied after negedge, outputs checked mid-low-phase
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].i_rd, vq[i].i_addr, vq[i].d_rd, vq[i].d_wr, vq[i].d_addr,
            vq[i].d_wdata, vq[i].resp);
      #2;
      chk_outputs("vec", i, vq[i].e_rd, vq[i].e_wr, vq[i].e_addr, vq[i].e_wdata,
                  vq[i].e_iresp, vq[i].e_dresp, vq[i].e_ld);
      chk("vec.state",  i, 128'(dut.state_q),    128'(vq[i].e_state));
      chk("vec.starve", i, 128'(dut.starve_cnt), 128'(vq[i].e_starve));
    end

    // Starvation bound: dcache always requesting, icache held; memory answers at once
    d_grants = 0;
    got_i    = 1'b0;
    for (int c = 0; c < 60 && !got_i; c++) begin
      @(negedge clk);
      drive(1, 16'h0100, 1, 0, 16'h9000, '0, 0);
      #1;
      bus.pmem_resp = bus.pmem_read;
      #1;
      if (bus.dcache_pmem_resp) d_grants++;
      if (bus.icache_pmem_resp) got_i = 1'b1;
    end
    chk("starve.icache_served", 0, 128'(got_i),    128'(1));
    chk("starve.d_grants",      0, 128'(d_grants), 128'(4));
    @(negedge clk);
    drive(0, '0, 0, 0, '0, '0, 0);
    #2;
    chk("starve.state_after", 0, 128'(dut.state_q),    128'(IDLE));
    chk("starve.cnt_after",   0, 128'(dut.starve_cnt), 128'(0));
    chk("starve.ld_after",    0, 128'(bus.ld_regs),    128'(1));

    // Reset in the middle of a dcache grant
    @(negedge clk);
    drive(0, '0, 1, 0, 16'h8000, '0, 0);
    @(negedge clk);
    #2;
    chk("rstmid.pmem_read_before", 0, 128'(bus.pmem_read), 128'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid.pmem_read_async", 0, 128'(bus.pmem_read),    128'(0));
    chk("rstmid.state",           0, 128'(dut.state_q),      128'(IDLE));
    chk("rstmid.addr",            0, 128'(bus.pmem_address), 128'(0));
    @(negedge clk);
    drive(0, '0, 0, 0, '0, '0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #2;
    chk("rstmid.late_dresp", 0, 128'(bus.dcache_pmem_resp), 128'(0));
    chk("rstmid.late_iresp", 0, 128'(bus.icache_pmem_resp), 128'(0));
    chk("rstmid.ld",         0, 128'(bus.ld_regs),          128'(1));
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #2;
    chk("rstmid.state_after", 0, 128'(dut.state_q), 128'(IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
